// File: rtl/si_statistics_poller.sv
// si_statistics_poller: Wishbone initiator that walks the statistics slave's
// register map and publishes one coherent snapshot. Each pass issues 16 single
// reads (64-bit counters LSB then MSB), optionally followed by a write of the
// slave's reset register.
// Register map (offsets from BASE_ADDR):
//   0 magic 'stat', 8 reset reg (write only), 12 packet_rate, 16 word_rate,
//   24/28 received_packets, 32/36 received_words, 40 size_of_last_packet,
//   44 invalid_packets, 48 packet_loss[0], 52 tag_rate, 56/60 received_tags,
//   64 overflow[1:0], 72/76 missed_tags.
module si_statistics_poller #(
  parameter int unsigned POLL_PERIOD = 33333333,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        clear_req_i,
  input  logic [2:0]  clear_mask_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        snap_valid_o,
  output logic [31:0] packet_rate_o,
  output logic [31:0] word_rate_o,
  output logic [31:0] tag_rate_o,
  output logic [63:0] received_packets_o,
  output logic [63:0] received_words_o,
  output logic [63:0] received_tags_o,
  output logic [63:0] missed_tags_o,
  output logic [31:0] size_of_last_packet_o,
  output logic [31:0] invalid_packets_o,
  output logic        packet_loss_o,
  output logic [1:0]  overflow_o,
  output logic        error_o,
  output logic [1:0]  error_code_o
);

  localparam logic [31:0] MAGIC      = 32'h7374_6174;
  localparam logic [31:0] TMO_LAST   = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] TMR_RELOAD = (POLL_PERIOD == 0) ? 32'd0 : 32'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, CLEAR, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        wr_q, wr_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] tmr_q;
  logic        pass_pend_q, pass_pend_d;
  logic        clr_pend_q, clr_pend_d;
  logic [2:0]  clr_mask_q, clr_mask_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        tick, cap, publish;

  // Shadow copies collected during the pass; missed_tags MSB comes straight off the bus.
  logic [31:0] sh_prate, sh_wrate, sh_trate, sh_size, sh_inval, sh_mt_lo;
  logic [63:0] sh_rxp, sh_rxw, sh_rxt;
  logic        sh_loss;
  logic [1:0]  sh_ovf;

  function automatic logic [6:0] rd_off(input logic [3:0] i);
    case (i)
      4'd0:    return 7'd0;
      4'd1:    return 7'd12;
      4'd2:    return 7'd16;
      4'd3:    return 7'd24;
      4'd4:    return 7'd28;
      4'd5:    return 7'd32;
      4'd6:    return 7'd36;
      4'd7:    return 7'd40;
      4'd8:    return 7'd44;
      4'd9:    return 7'd48;
      4'd10:   return 7'd52;
      4'd11:   return 7'd56;
      4'd12:   return 7'd60;
      4'd13:   return 7'd64;
      4'd14:   return 7'd72;
      default: return 7'd76;
    endcase
  endfunction

  assign tick = (POLL_PERIOD != 0) && (tmr_q == 32'd0);

  // Free-running poll timer; reloads whenever it fires.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                tmr_q <= TMR_RELOAD;
    else if (POLL_PERIOD != 0) tmr_q <= tick ? TMR_RELOAD : tmr_q - 32'd1;

  // Next-state logic: one bus transaction at a time, stb only in REQ/CLEAR.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    tmo_d       = tmo_q;
    pass_pend_d = pass_pend_q | start_i | tick;
    clr_pend_d  = clr_pend_q | clear_req_i;
    clr_mask_d  = clr_mask_q | (clear_req_i ? clear_mask_i : 3'b0);
    err_code_d  = err_code_q;
    cap         = 1'b0;
    publish     = 1'b0;
    case (state_q)
      IDLE: if (pass_pend_d) begin
        state_d     = REQ;
        idx_d       = 4'd0;
        wr_d        = 1'b0;
        pass_pend_d = 1'b0;
        err_code_d  = 2'd0;
      end
      REQ: begin
        tmo_d   = 32'd1;
        state_d = WAIT;
      end
      CLEAR: begin
        tmo_d   = 32'd1;
        wr_d    = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (wb_ack_i) begin
        if (wr_q) begin
          state_d    = GAP;
          clr_pend_d = clear_req_i;
          clr_mask_d = clear_req_i ? clear_mask_i : 3'b0;
        end else if (idx_q == 4'd0 && wb_dat_i != MAGIC) begin
          state_d    = ERR;
          err_code_d = 2'd1;
        end else if (idx_q == 4'd15) begin
          state_d = DONE;
          publish = 1'b1;
        end else begin
          state_d = GAP;
          cap     = 1'b1;
        end
      end else if (tmo_q >= TMO_LAST) begin
        state_d    = ERR;
        err_code_d = 2'd2;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
      GAP: if (wr_q) state_d = IDLE;
           else begin
             state_d = REQ;
             idx_d   = idx_q + 4'd1;
           end
      DONE:    state_d = clr_pend_d ? CLEAR : IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      wr_q        <= 1'b0;
      tmo_q       <= 32'd0;
      pass_pend_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      clr_mask_q  <= 3'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      tmo_q       <= tmo_d;
      pass_pend_q <= pass_pend_d;
      clr_pend_q  <= clr_pend_d;
      clr_mask_q  <= clr_mask_d;
      err_code_q  <= err_code_d;
    end

  // Capture each acked read word into its shadow field.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_prate <= '0; sh_wrate <= '0; sh_trate <= '0; sh_size <= '0;
      sh_inval <= '0; sh_mt_lo <= '0; sh_rxp <= '0; sh_rxw <= '0;
      sh_rxt <= '0; sh_loss <= 1'b0; sh_ovf <= '0;
    end else if (cap) begin
      case (idx_q)
        4'd1:  sh_prate        <= wb_dat_i;
        4'd2:  sh_wrate        <= wb_dat_i;
        4'd3:  sh_rxp[31:0]    <= wb_dat_i;
        4'd4:  sh_rxp[63:32]   <= wb_dat_i;
        4'd5:  sh_rxw[31:0]    <= wb_dat_i;
        4'd6:  sh_rxw[63:32]   <= wb_dat_i;
        4'd7:  sh_size         <= wb_dat_i;
        4'd8:  sh_inval        <= wb_dat_i;
        4'd9:  sh_loss         <= wb_dat_i[0];
        4'd10: sh_trate        <= wb_dat_i;
        4'd11: sh_rxt[31:0]    <= wb_dat_i;
        4'd12: sh_rxt[63:32]   <= wb_dat_i;
        4'd13: sh_ovf          <= wb_dat_i[1:0];
        4'd14: sh_mt_lo        <= wb_dat_i;
        default: ;
      endcase
    end

  // Publish the whole snapshot at once on the final ack; aborted passes never get here.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      packet_rate_o <= '0; word_rate_o <= '0; tag_rate_o <= '0;
      received_packets_o <= '0; received_words_o <= '0; received_tags_o <= '0;
      missed_tags_o <= '0; size_of_last_packet_o <= '0; invalid_packets_o <= '0;
      packet_loss_o <= 1'b0; overflow_o <= '0;
    end else if (publish) begin
      packet_rate_o         <= sh_prate;
      word_rate_o           <= sh_wrate;
      tag_rate_o            <= sh_trate;
      received_packets_o    <= sh_rxp;
      received_words_o      <= sh_rxw;
      received_tags_o       <= sh_rxt;
      missed_tags_o         <= {wb_dat_i, sh_mt_lo};
      size_of_last_packet_o <= sh_size;
      invalid_packets_o     <= sh_inval;
      packet_loss_o         <= sh_loss;
      overflow_o            <= sh_ovf;
    end

  // Bus outputs decoded from state so a reset drops cyc/stb immediately.
  always_comb begin
    wb_cyc_o = (state_q == REQ) || (state_q == CLEAR) || (state_q == WAIT);
    wb_stb_o = (state_q == REQ) || (state_q == CLEAR);
    wb_we_o  = (state_q == CLEAR) || (state_q == WAIT && wr_q);
    wb_adr_o = 32'd0;
    if (wb_we_o)                                     wb_adr_o = BASE_ADDR + 32'd8;
    else if (state_q == REQ || state_q == WAIT)      wb_adr_o = BASE_ADDR + 32'(rd_off(idx_q));
    wb_dat_o = wb_we_o ? {29'b0, clr_mask_q} : 32'd0;
  end

  assign busy_o       = (state_q != IDLE);
  assign snap_valid_o = (state_q == DONE);
  assign error_o      = (state_q == ERR);
  assign error_code_o = err_code_q;

endmodule
